// File: rtl/alu_result_fifo_pkg.sv
// Shared definitions for the ALU result capture FIFO: widths, occupancy
// state encoding and the signature step used by both design and bench.
package alu_result_fifo_pkg;

    localparam int RES_W = 8;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Rotate left by one, then fold in the new result word.
    function automatic logic [RES_W-1:0] sig_step(input logic [RES_W-1:0] sig,
                                                  input logic [RES_W-1:0] din);
        return {sig[RES_W-2:0], sig[RES_W-1]} ^ din;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous (combinational) read.
module fifo_mem_2p #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy logic guarantees stale entries are never
    // presented, and a reset-free array maps onto plain RAM/register-file cells.
    // NOTE: clocked state is always written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through capture buffer for tagged ALU/mux results, with
// occupancy tracking, sticky overflow and a running rotate-xor signature.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] Din,
    input  logic [SEL_W-1:0]  SelIn,
    input  logic              CapEn,
    output logic [DATA_W-1:0] DoutData,
    output logic [SEL_W-1:0]  DoutSel,
    output logic              DoutValid,
    input  logic              DoutReady,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic              Overflow,
    input  logic              ClrOvf,
    output logic [DATA_W-1:0] Signature
);

    localparam int ENTRY_W = DATA_W + SEL_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    occ_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count_q, count_d;
    logic                push, pop, drop;
    logic [ENTRY_W-1:0]  rd_entry;

    assign pop  = DoutValid & DoutReady;
    assign push = CapEn & (~Full | pop);
    assign drop = CapEn & Full & ~pop;

    fifo_mem_2p #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (Clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({SelIn, Din}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy FSM: state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push && !pop) state_d = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (count_d == FULL_COUNT)  state_d = OCC_FULL;
                else if (count_d == '0)     state_d = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push) state_d = OCC_PARTIAL;
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // Occupancy FSM: output decode.
    always_comb begin
        Full      = (state_q == OCC_FULL);
        Empty     = (state_q == OCC_EMPTY);
        DoutValid = (state_q != OCC_EMPTY);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            Overflow  <= 1'b0;
            Signature <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                Signature <= sig_step(Signature, Din);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                Overflow <= 1'b1;
            end else if (ClrOvf) begin
                Overflow <= 1'b0;
            end
        end
    end

    assign Count    = count_q;
    assign DoutData = Empty ? '0 : rd_entry[DATA_W-1:0];
    assign DoutSel  = Empty ? '0 : rd_entry[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo: reset, signature, fill/overflow,
// overflow clear, full push+pop, pointer wrap and asynchronous reset mid-stream.
module tb_alu_result_fifo;
    import alu_result_fifo_pkg::*;

    logic       Clk;
    logic       Rst_n;
    logic [7:0] Din;
    logic [1:0] SelIn;
    logic       CapEn;
    logic [7:0] DoutData;
    logic [1:0] DoutSel;
    logic       DoutValid;
    logic       DoutReady;
    logic [3:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       ClrOvf;
    logic [7:0] Signature;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_sig;

    alu_result_fifo #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Din       (Din),
        .SelIn     (SelIn),
        .CapEn     (CapEn),
        .DoutData  (DoutData),
        .DoutSel   (DoutSel),
        .DoutValid (DoutValid),
        .DoutReady (DoutReady),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .ClrOvf    (ClrOvf),
        .Signature (Signature)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1; Din = '0; SelIn = '0; CapEn = 1'b0; DoutReady = 1'b0; ClrOvf = 1'b0;
        #1 Rst_n = 1'b0;
        #2;
        total++; if (Count !== 4'd0)     begin bad++; $display("FAIL rst_count got=%0d want=0", Count); end
        total++; if (Empty !== 1'b1)     begin bad++; $display("FAIL rst_empty got=%b want=1", Empty); end
        total++; if (Full !== 1'b0)      begin bad++; $display("FAIL rst_full got=%b want=0", Full); end
        total++; if (DoutValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", DoutValid); end
        total++; if (DoutData !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", DoutData); end
        total++; if (DoutSel !== 2'd0)   begin bad++; $display("FAIL rst_sel got=%0d want=0", DoutSel); end
        total++; if (Overflow !== 1'b0)  begin bad++; $display("FAIL rst_ovf got=%b want=0", Overflow); end
        total++; if (Signature !== 8'h00) begin bad++; $display("FAIL rst_sig got=%h want=00", Signature); end
        #9 Rst_n = 1'b1;
        tick();
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL rel_empty got=%b want=1", Empty); end
    endtask

    task automatic test_signature();
        DoutReady = 1'b0; SelIn = 2'd0;
        CapEn = 1'b1; Din = 8'h12;
        tick();
        total++; if (Signature !== 8'h12) begin bad++; $display("FAIL sig_first got=%h want=12", Signature); end
        total++; if (DoutValid !== 1'b1)  begin bad++; $display("FAIL sig_valid got=%b want=1", DoutValid); end
        Din = 8'h34;
        tick();
        CapEn = 1'b0;
        total++; if (Count !== 4'd2)      begin bad++; $display("FAIL sig_count got=%0d want=2", Count); end
        total++; if (Signature !== 8'h10) begin bad++; $display("FAIL sig_second got=%h want=10", Signature); end
        total++; if (DoutData !== 8'h12)  begin bad++; $display("FAIL sig_head got=%h want=12", DoutData); end
        exp_sig = 8'h10;
        DoutReady = 1'b1;
        tick();
        total++; if (DoutData !== 8'h34) begin bad++; $display("FAIL sig_head2 got=%h want=34", DoutData); end
        tick();
        DoutReady = 1'b0;
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL sig_drained got=%b want=1", Empty); end
        total++; if (Signature !== 8'h10) begin bad++; $display("FAIL sig_pop_keep got=%h want=10", Signature); end
    endtask

    task automatic test_fill_overflow();
        DoutReady = 1'b0; SelIn = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            CapEn = 1'b1; Din = 8'(i);
            tick();
            exp_sig = sig_step(exp_sig, 8'(i));
        end
        total++; if (Count !== 4'd8)    begin bad++; $display("FAIL fill_count got=%0d want=8", Count); end
        total++; if (Full !== 1'b1)     begin bad++; $display("FAIL fill_full got=%b want=1", Full); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf0 got=%b want=0", Overflow); end
        Din = 8'hAA;
        tick();
        CapEn = 1'b0;
        total++; if (Overflow !== 1'b1)     begin bad++; $display("FAIL drop_ovf got=%b want=1", Overflow); end
        total++; if (Count !== 4'd8)        begin bad++; $display("FAIL drop_count got=%0d want=8", Count); end
        total++; if (Signature !== exp_sig) begin bad++; $display("FAIL drop_sig got=%h want=%h", Signature, exp_sig); end
        DoutReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (DoutData !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, DoutData, 8'(i)); end
            total++; if (DoutSel !== 2'd3)   begin bad++; $display("FAIL drain_sel[%0d] got=%0d want=3", i, DoutSel); end
            tick();
        end
        DoutReady = 1'b0;
        total++; if (Empty !== 1'b1)     begin bad++; $display("FAIL drain_empty got=%b want=1", Empty); end
        total++; if (Count !== 4'd0)     begin bad++; $display("FAIL drain_count got=%0d want=0", Count); end
        total++; if (DoutData !== 8'h00) begin bad++; $display("FAIL drain_data0 got=%h want=00", DoutData); end
    endtask

    task automatic test_ovf_clear();
        // Overflow is still set from the previous drop; refill and exercise clearing.
        DoutReady = 1'b0; SelIn = 2'd1;
        for (int i = 0; i < 8; i++) begin
            CapEn = 1'b1; Din = 8'h81 + 8'(i);
            tick();
            exp_sig = sig_step(exp_sig, 8'h81 + 8'(i));
        end
        Din = 8'hEE; ClrOvf = 1'b1;
        tick();
        CapEn = 1'b0;
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL clr_with_drop got=%b want=1", Overflow); end
        tick();
        ClrOvf = 1'b0;
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", Overflow); end
        total++; if (Count !== 4'd8)    begin bad++; $display("FAIL clr_count got=%0d want=8", Count); end
        total++; if (Signature !== exp_sig) begin bad++; $display("FAIL clr_sig got=%h want=%h", Signature, exp_sig); end
    endtask

    task automatic test_full_push_pop();
        CapEn = 1'b1; Din = 8'h55; SelIn = 2'd2; DoutReady = 1'b1;
        tick();
        CapEn = 1'b0;
        exp_sig = sig_step(exp_sig, 8'h55);
        total++; if (Count !== 4'd8)    begin bad++; $display("FAIL fpp_count got=%0d want=8", Count); end
        total++; if (Full !== 1'b1)     begin bad++; $display("FAIL fpp_full got=%b want=1", Full); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b want=0", Overflow); end
        total++; if (Signature !== exp_sig) begin bad++; $display("FAIL fpp_sig got=%h want=%h", Signature, exp_sig); end
        for (int i = 0; i < 7; i++) begin
            total++; if (DoutData !== 8'h82 + 8'(i)) begin bad++; $display("FAIL fpp_data[%0d] got=%h want=%h", i, DoutData, 8'h82 + 8'(i)); end
            total++; if (DoutSel !== 2'd1) begin bad++; $display("FAIL fpp_sel[%0d] got=%0d want=1", i, DoutSel); end
            tick();
        end
        total++; if (DoutData !== 8'h55) begin bad++; $display("FAIL fpp_eighth got=%h want=55", DoutData); end
        total++; if (DoutSel !== 2'd2)   begin bad++; $display("FAIL fpp_eighth_sel got=%0d want=2", DoutSel); end
        tick();
        DoutReady = 1'b0;
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b want=1", Empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] nxt_out;
        DoutReady = 1'b0; SelIn = 2'd0;
        for (int i = 0; i < 3; i++) begin
            CapEn = 1'b1; Din = 8'h10 + 8'(i);
            tick();
            exp_sig = sig_step(exp_sig, 8'h10 + 8'(i));
        end
        total++; if (Count !== 4'd3) begin bad++; $display("FAIL wrap_count3 got=%0d want=3", Count); end
        DoutReady = 1'b1;
        nxt_out = 8'h10;
        for (int i = 3; i < 20; i++) begin
            Din = 8'h10 + 8'(i);
            total++; if (DoutData !== nxt_out) begin bad++; $display("FAIL wrap_data got=%h want=%h", DoutData, nxt_out); end
            tick();
            exp_sig = sig_step(exp_sig, 8'h10 + 8'(i));
            nxt_out++;
            total++; if (Count !== 4'd3) begin bad++; $display("FAIL wrap_count got=%0d want=3", Count); end
        end
        CapEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (DoutData !== nxt_out) begin bad++; $display("FAIL wrap_tail got=%h want=%h", DoutData, nxt_out); end
            tick();
            nxt_out++;
        end
        DoutReady = 1'b0;
        total++; if (Empty !== 1'b1)        begin bad++; $display("FAIL wrap_empty got=%b want=1", Empty); end
        total++; if (Signature !== exp_sig) begin bad++; $display("FAIL wrap_sig got=%h want=%h", Signature, exp_sig); end
    endtask

    task automatic test_async_reset();
        DoutReady = 1'b0; SelIn = 2'd1;
        for (int i = 0; i < 5; i++) begin
            CapEn = 1'b1; Din = 8'hC0 + 8'(i);
            tick();
        end
        CapEn = 1'b0;
        total++; if (Count !== 4'd5) begin bad++; $display("FAIL ar_pre_count got=%0d want=5", Count); end
        #2 Rst_n = 1'b0;
        #1;
        total++; if (Count !== 4'd0)      begin bad++; $display("FAIL ar_count got=%0d want=0", Count); end
        total++; if (Empty !== 1'b1)      begin bad++; $display("FAIL ar_empty got=%b want=1", Empty); end
        total++; if (DoutValid !== 1'b0)  begin bad++; $display("FAIL ar_valid got=%b want=0", DoutValid); end
        total++; if (DoutData !== 8'h00)  begin bad++; $display("FAIL ar_data got=%h want=00", DoutData); end
        total++; if (Signature !== 8'h00) begin bad++; $display("FAIL ar_sig got=%h want=00", Signature); end
        #2 Rst_n = 1'b1;
        CapEn = 1'b1; Din = 8'h7E; SelIn = 2'd2; DoutReady = 1'b1;
        tick();
        CapEn = 1'b0;
        total++; if (DoutValid !== 1'b1)  begin bad++; $display("FAIL ar_push_valid got=%b want=1", DoutValid); end
        total++; if (DoutData !== 8'h7E)  begin bad++; $display("FAIL ar_push_data got=%h want=7e", DoutData); end
        total++; if (DoutSel !== 2'd2)    begin bad++; $display("FAIL ar_push_sel got=%0d want=2", DoutSel); end
        total++; if (Count !== 4'd1)      begin bad++; $display("FAIL ar_push_count got=%0d want=1", Count); end
        total++; if (Signature !== 8'h7E) begin bad++; $display("FAIL ar_push_sig got=%h want=7e", Signature); end
        tick();
        DoutReady = 1'b0;
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL ar_pop_empty got=%b want=1", Empty); end
        total++; if (Count !== 4'd0) begin bad++; $display("FAIL ar_pop_count got=%0d want=0", Count); end
    endtask

    initial begin
        test_reset();
        test_signature();
        test_fill_overflow();
        test_ovf_clear();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
